// File: rtl/fuel_dispense_ctrl_pkg.sv
// Shared state encoding and price constants for the fuel dispense controller.
package fuel_pkg;

  localparam int PRICE_W    = 17;
  localparam int PRICE_STEP = 1000;
  localparam int MAX_TARGET = 131000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    PUMP  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/fuel_dispense_ctrl_wdog.sv
// Pump stall detector: counts PUMP cycles with an unchanging price and flags expiry.
// Only compiled and instantiated when DISPENSE_WDOG_EN is defined.
`ifdef DISPENSE_WDOG_EN
module dispense_wdog #(
  parameter int PRICE_W     = 17,
  parameter int WDOG_CYCLES = 3500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_i,
  input  logic [PRICE_W-1:0] price_i,
  output logic               expired_o
);

  localparam int               CNT_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_CYCLES - 1);

  logic [PRICE_W-1:0] price_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               changed;

  assign changed = (price_i != price_q);

  // Counter sits at zero outside PUMP, so every PUMP entry starts a fresh window.
  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    price_q <= price_i;
  end

  assign expired_o = run_i && !changed && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/fuel_dispense_ctrl.sv
// Preset-amount dispense controller: latches a target, clears the price counter and runs the pump relay.
// Defining DISPENSE_WDOG_EN adds a stall watchdog that ends a frozen PUMP in FAULT.
module fuel_dispense_ctrl #(
  parameter int PRICE_W          = fuel_pkg::PRICE_W,
  parameter int MAX_TARGET       = fuel_pkg::MAX_TARGET,
  parameter int WDOG_CYCLES      = 3500000,
  parameter int DONE_HOLD_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [PRICE_W-1:0] target_price,
  input  logic [PRICE_W-1:0] price_in,
  output logic               relay_auto,
  output logic               price_clr,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               fault
);

  import fuel_pkg::*;

  localparam int                 HOLD_W    = (DONE_HOLD_CYCLES > 1) ? $clog2(DONE_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(DONE_HOLD_CYCLES - 1);
  localparam logic [PRICE_W-1:0] TGT_CEIL  = PRICE_W'(MAX_TARGET);

  state_e             state_q;
  logic [PRICE_W-1:0] tgt_q, tgt_sat_d;
  logic [HOLD_W-1:0]  hold_q;
  logic               zero_seen_q;
  logic               relay_q, clr_q, busy_q, done_q, aborted_q, fault_q;
  logic               wdog_exp;

  // Clamp keeps the overshoot of the final step from wrapping the price counter.
  assign tgt_sat_d = (target_price > TGT_CEIL) ? TGT_CEIL : target_price;

`ifdef DISPENSE_WDOG_EN
  dispense_wdog #(
    .PRICE_W     (PRICE_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .run_i     (state_q == PUMP),
    .price_i   (price_in),
    .expired_o (wdog_exp)
  );
`else
  logic wdog_cfg_unused;
  assign wdog_cfg_unused = (WDOG_CYCLES > 0);
  assign wdog_exp        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      hold_q      <= '0;
      zero_seen_q <= 1'b0;
      relay_q     <= 1'b0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !stop && (target_price != '0)) begin
            state_q     <= ARM;
            tgt_q       <= tgt_sat_d;
            zero_seen_q <= 1'b0;
            clr_q       <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        // A zero price is recorded first and acted on one edge later, so ARM lasts at least two cycles.
        ARM: begin
          if (stop) begin
            state_q   <= DONE;
            hold_q    <= '0;
            clr_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (zero_seen_q) begin
            state_q <= PUMP;
            clr_q   <= 1'b0;
            relay_q <= 1'b1;
          end else if (price_in == '0) begin
            zero_seen_q <= 1'b1;
          end
        end
        PUMP: begin
          if (stop || (price_in >= tgt_q)) begin
            state_q   <= DONE;
            hold_q    <= '0;
            relay_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= stop;
          end else if (wdog_exp) begin
            state_q <= FAULT;
            hold_q  <= '0;
            relay_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b1;
          end
        end
        DONE, FAULT: begin
          if (stop || (hold_q == HOLD_LAST)) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            fault_q   <= 1'b0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign relay_auto = relay_q;
  assign price_clr  = clr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign fault      = fault_q;

endmodule
